// File: rtl/mem_arbiter.sv
// Arbiter sharing one memory-controller request channel between lsb, icache and prefetcher.
// Optional fair mode (icache anti-starvation counter) is enabled by defining MEM_ARB_FAIR_EN.
`timescale 1ns/1ps

module mem_arbiter #(
    parameter logic [31:0] IO_BASE      = 32'h00030000,
    parameter int          STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic        clear,
    input  logic        io_buffer_full,
    input  logic        lsb_req,
    input  logic        lsb_type,
    input  logic [31:0] lsb_addr,
    input  logic [1:0]  lsb_len,
    input  logic [31:0] lsb_wdata,
    output logic        lsb_done,
    output logic [31:0] lsb_rdata,
    input  logic        ic_req,
    input  logic [31:0] ic_addr,
    output logic        ic_done,
    output logic [31:0] ic_rdata,
    input  logic        pf_req,
    input  logic [31:0] pf_addr,
    output logic        pf_done,
    output logic [31:0] pf_rdata,
    output logic        mc_in_flag,
    output logic        mc_type,
    output logic [31:0] mc_addr,
    output logic [1:0]  mc_len,
    output logic [31:0] mc_wdata,
    input  logic        mc_out_flag,
    input  logic [31:0] mc_rdata
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_HOLD = 2'd2} state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_LSB  = 2'd1;
    localparam logic [1:0] OWN_IC   = 2'd2;
    localparam logic [1:0] OWN_PF   = 2'd3;

    state_t      state_r, state_s;
    logic [1:0]  owner_r, owner_s, grant_s;
    logic        lsb_elig_s, force_ic_s, abort_s;
    logic        mc_in_flag_r, mc_in_flag_s, mc_type_r, mc_type_s;
    logic [31:0] mc_addr_r, mc_addr_s, mc_wdata_r, mc_wdata_s;
    logic [1:0]  mc_len_r, mc_len_s;
    logic        lsb_done_r, lsb_done_s, ic_done_r, ic_done_s, pf_done_r, pf_done_s;
    logic [31:0] lsb_rdata_r, lsb_rdata_s, ic_rdata_r, ic_rdata_s, pf_rdata_r, pf_rdata_s;

`ifdef MEM_ARB_FAIR_EN
    logic [2:0]  starve_cnt_r, starve_cnt_s;

    // Starvation counter: counts lsb wins over a waiting icache, cleared by icache grant or flush.
    always_comb begin
        starve_cnt_s = starve_cnt_r;
        if (clear) begin
            starve_cnt_s = 3'd0;
        end else if (state_r == ST_IDLE && grant_s == OWN_IC) begin
            starve_cnt_s = 3'd0;
        end else if (state_r == ST_IDLE && grant_s == OWN_LSB && ic_req && starve_cnt_r != 3'd7) begin
            starve_cnt_s = starve_cnt_r + 3'd1;
        end else begin
            starve_cnt_s = starve_cnt_r;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt_r <= 3'd0;
        end else if (ready) begin
            starve_cnt_r <= starve_cnt_s;
        end
    end

    assign force_ic_s = (starve_cnt_r >= 3'(STARVE_LIMIT));
`else
    assign force_ic_s = 1'b0;
`endif

    // I/O stores are held back while the UART buffer is full; reads on clear are not worth issuing.
    always_comb begin
        lsb_elig_s = lsb_req && !(lsb_type && (lsb_addr >= IO_BASE) && io_buffer_full);
        if (clear) begin
            grant_s = OWN_NONE;
        end else if (force_ic_s && ic_req) begin
            grant_s = OWN_IC;
        end else if (lsb_elig_s) begin
            grant_s = OWN_LSB;
        end else if (ic_req) begin
            grant_s = OWN_IC;
        end else if (pf_req) begin
            grant_s = OWN_PF;
        end else begin
            grant_s = OWN_NONE;
        end
    end

    // Only reads are abortable; an in-flight store must complete.
    assign abort_s = clear && !mc_type_r;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else if (ready) begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: state_s = (grant_s != OWN_NONE) ? ST_BUSY : ST_IDLE;
            ST_BUSY: begin
                if (abort_s) begin
                    state_s = ST_IDLE;
                end else if (mc_out_flag) begin
                    state_s = ST_HOLD;
                end else begin
                    state_s = ST_BUSY;
                end
            end
            ST_HOLD: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs; done flags default low so they pulse for one cycle.
    always_comb begin
        owner_s      = owner_r;
        mc_in_flag_s = mc_in_flag_r;
        mc_type_s    = mc_type_r;
        mc_addr_s    = mc_addr_r;
        mc_len_s     = mc_len_r;
        mc_wdata_s   = mc_wdata_r;
        lsb_done_s   = 1'b0;
        ic_done_s    = 1'b0;
        pf_done_s    = 1'b0;
        lsb_rdata_s  = lsb_rdata_r;
        ic_rdata_s   = ic_rdata_r;
        pf_rdata_s   = pf_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s != OWN_NONE) begin
                    owner_s      = grant_s;
                    mc_in_flag_s = 1'b1;
                    if (grant_s == OWN_LSB) begin
                        mc_type_s  = lsb_type;
                        mc_addr_s  = lsb_addr;
                        mc_len_s   = lsb_len;
                        mc_wdata_s = lsb_wdata;
                    end else begin
                        mc_type_s  = 1'b0;
                        mc_addr_s  = (grant_s == OWN_IC) ? ic_addr : pf_addr;
                        mc_len_s   = 2'd3;
                        mc_wdata_s = 32'h0000_0000;
                    end
                end else begin
                    mc_in_flag_s = 1'b0;
                end
            end
            ST_BUSY: begin
                if (abort_s) begin
                    mc_in_flag_s = 1'b0;
                end else if (mc_out_flag) begin
                    mc_in_flag_s = 1'b0;
                    case (owner_r)
                        OWN_LSB: begin lsb_done_s = 1'b1; lsb_rdata_s = mc_rdata; end
                        OWN_IC:  begin ic_done_s  = 1'b1; ic_rdata_s  = mc_rdata; end
                        OWN_PF:  begin pf_done_s  = 1'b1; pf_rdata_s  = mc_rdata; end
                        default: mc_in_flag_s = 1'b0;
                    endcase
                end else begin
                    mc_in_flag_s = 1'b1;
                end
            end
            ST_HOLD: mc_in_flag_s = 1'b0;
            default: mc_in_flag_s = 1'b0;
        endcase
    end

    // Output and ownership registers; a low ready freezes everything, including done pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_r      <= OWN_NONE;
            mc_in_flag_r <= 1'b0;
            mc_type_r    <= 1'b0;
            mc_addr_r    <= 32'h0000_0000;
            mc_len_r     <= 2'd0;
            mc_wdata_r   <= 32'h0000_0000;
            lsb_done_r   <= 1'b0;
            ic_done_r    <= 1'b0;
            pf_done_r    <= 1'b0;
            lsb_rdata_r  <= 32'h0000_0000;
            ic_rdata_r   <= 32'h0000_0000;
            pf_rdata_r   <= 32'h0000_0000;
        end else if (ready) begin
            owner_r      <= owner_s;
            mc_in_flag_r <= mc_in_flag_s;
            mc_type_r    <= mc_type_s;
            mc_addr_r    <= mc_addr_s;
            mc_len_r     <= mc_len_s;
            mc_wdata_r   <= mc_wdata_s;
            lsb_done_r   <= lsb_done_s;
            ic_done_r    <= ic_done_s;
            pf_done_r    <= pf_done_s;
            lsb_rdata_r  <= lsb_rdata_s;
            ic_rdata_r   <= ic_rdata_s;
            pf_rdata_r   <= pf_rdata_s;
        end
    end

    assign mc_in_flag = mc_in_flag_r;
    assign mc_type    = mc_type_r;
    assign mc_addr    = mc_addr_r;
    assign mc_len     = mc_len_r;
    assign mc_wdata   = mc_wdata_r;
    assign lsb_done   = lsb_done_r;
    assign ic_done    = ic_done_r;
    assign pf_done    = pf_done_r;
    assign lsb_rdata  = lsb_rdata_r;
    assign ic_rdata   = ic_rdata_r;
    assign pf_rdata   = pf_rdata_r;

endmodule
